// File: rtl/j1_uart_pkg.sv
// rtl/j1_uart_pkg.sv - shared types and register layout for the J1 UART slave
package uart_pkg;

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_DIV    = 2'd2,
      REG_RSVD   = 2'd3
   } reg_ofs_t;

   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_IDLE  = 1;
   localparam int ST_RX_VALID = 2;
   localparam int ST_RX_OVR   = 3;
   localparam int ST_RX_FERR  = 4;
   localparam int ST_TXOVR    = 5;
   localparam int ST_RXIE     = 8;
   localparam int ST_TXIE     = 9;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   // RX_WAIT_HIGH holds off restart after a framing error until the line idles.
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

endpackage

// File: rtl/j1_uart_sync_fifo.sv
// rtl/j1_uart_sync_fifo.sv - small synchronous FIFO with registered read data
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             push_ok, pop_ok;

   assign full   = (count_q == DEPTH_C);
   assign empty  = (count_q == '0);
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      rd_data_d = rd_data_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok) begin
         rd_ptr_d  = rd_ptr_q + 1'b1;
         rd_data_d = mem_q[rd_ptr_q];
      end
      if (push_ok && !pop_ok) count_d = count_q + 1'b1;
      else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = rd_data_q;

endmodule

// File: rtl/j1_uart.sv
// rtl/j1_uart.sv - memory-mapped 8N1 UART slave on the J1 data bus
// Define J1_UART_IRQ_EN to enable the rxie/txie interrupt logic.
module j1_uart
   import uart_pkg::*;
#(
   parameter logic [15:0] BASE_ADR  = 16'h3FFC,
   parameter int          TX_DEPTH  = 4,
   parameter logic [15:0] DIV_RESET = 16'd433
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] dbus_adr,
   input  logic        dbus_re,
   input  logic        dbus_we,
   input  logic [15:0] dbus_dat_w,
   output logic [15:0] dbus_dat_r,
   input  logic        uart_rxd,
   output logic        uart_txd,
   output logic        irq
);
   logic       sel, wr, rd, rd_data, rd_status;
   reg_ofs_t   ofs;
   logic       fifo_full, fifo_empty, fifo_push, tx_pop, tx_idle;
   logic [7:0] fifo_rdata;

   tx_state_t   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        txd_q, txd_d;

   rx_state_t   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
   logic        rx_s1_q, rx_s2_q, rx_prev_q;
   logic        rx_done, rx_ferr_evt;

   logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
   logic        rx_ferr_q, rx_ferr_d, txovr_q, txovr_d;
   logic [15:0] div_q, div_d, dat_r_q, dat_r_d, status_w;
   logic        rxie, txie;

   assign sel       = (dbus_adr[15:2] == BASE_ADR[15:2]);
   assign ofs       = reg_ofs_t'(dbus_adr[1:0]);
   assign wr        = dbus_we & sel;
   assign rd        = dbus_re & sel & ~dbus_we;
   assign rd_data   = rd & (ofs == REG_DATA);
   assign rd_status = rd & (ofs == REG_STATUS);
   assign fifo_push = wr & (ofs == REG_DATA);
   assign tx_idle   = fifo_empty & (tx_state_q == TX_IDLE);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (dbus_dat_w[7:0]),
      .pop       (tx_pop),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // TX: the popped byte appears on fifo_rdata during START and is loaded at its end.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_div_d   = tx_div_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            if (!fifo_empty) begin
               tx_pop     = 1'b1;
               tx_div_d   = div_q;
               tx_cnt_d   = div_q;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt_q == 16'd0) begin
               tx_shift_d = fifo_rdata;
               tx_bit_d   = 3'd0;
               tx_cnt_d   = tx_div_q;
               tx_state_d = TX_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == 16'd0) begin
               tx_cnt_d   = tx_div_q;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
               else tx_bit_d = tx_bit_q + 3'd1;
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == 16'd0) begin
               if (!fifo_empty) begin
                  tx_pop     = 1'b1;
                  tx_div_d   = div_q;
                  tx_cnt_d   = div_q;
                  tx_state_d = TX_START;
               end else begin
                  tx_state_d = TX_IDLE;
               end
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      case (tx_state_d)
         TX_START: txd_d = 1'b0;
         TX_DATA:  txd_d = tx_shift_d[0];
         default:  txd_d = 1'b1;
      endcase
   end

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_div_d    = rx_div_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_done     = 1'b0;
      rx_ferr_evt = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx_s2_q && rx_prev_q) begin
               rx_div_d   = div_q;
               rx_cnt_d   = {1'b0, div_q[15:1]};
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt_q == 16'd0) begin
               if (rx_s2_q) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_cnt_d   = rx_div_q;
                  rx_bit_d   = 3'd0;
                  rx_state_d = RX_DATA;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == 16'd0) begin
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               rx_cnt_d   = rx_div_q;
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               else rx_bit_d = rx_bit_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == 16'd0) begin
               if (rx_s2_q) begin
                  rx_done    = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_ferr_evt = 1'b1;
                  rx_state_d  = RX_WAIT_HIGH;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         RX_WAIT_HIGH: begin
            if (rx_s2_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      status_w              = 16'h0000;
      status_w[ST_TX_FULL]  = fifo_full;
      status_w[ST_TX_IDLE]  = tx_idle;
      status_w[ST_RX_VALID] = rx_valid_q;
      status_w[ST_RX_OVR]   = rx_ovr_q;
      status_w[ST_RX_FERR]  = rx_ferr_q;
      status_w[ST_TXOVR]    = txovr_q;
      status_w[ST_RXIE]     = rxie;
      status_w[ST_TXIE]     = txie;

      div_d = div_q;
      if (wr && ofs == REG_DIV) div_d = dbus_dat_w;

      // Sticky flags: a new event in the same cycle as a STATUS read wins over the clear.
      rx_byte_d  = rx_done ? rx_shift_q : rx_byte_q;
      rx_valid_d = (rx_valid_q & ~rd_data) | rx_done;
      rx_ovr_d   = (rx_ovr_q & ~rd_status) | (rx_done & rx_valid_q & ~rd_data);
      rx_ferr_d  = (rx_ferr_q & ~rd_status) | rx_ferr_evt;
      txovr_d    = (txovr_q & ~rd_status) | (fifo_push & fifo_full & ~tx_pop);

      dat_r_d = dat_r_q;
      if (dbus_re && !sel) begin
         dat_r_d = 16'h0000;
      end else if (rd) begin
         case (ofs)
            REG_DATA:   dat_r_d = {8'h00, rx_byte_q};
            REG_STATUS: dat_r_d = status_w;
            REG_DIV:    dat_r_d = div_q;
            default:    dat_r_d = 16'h0000;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_div_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         txd_q      <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_div_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_byte_q  <= '0;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_valid_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
         rx_ferr_q  <= 1'b0;
         txovr_q    <= 1'b0;
         div_q      <= DIV_RESET;
         dat_r_q    <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_div_q   <= tx_div_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_div_q   <= rx_div_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_byte_q  <= rx_byte_d;
         rx_s1_q    <= uart_rxd;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         rx_valid_q <= rx_valid_d;
         rx_ovr_q   <= rx_ovr_d;
         rx_ferr_q  <= rx_ferr_d;
         txovr_q    <= txovr_d;
         div_q      <= div_d;
         dat_r_q    <= dat_r_d;
      end
   end

`ifdef J1_UART_IRQ_EN
   logic rxie_q, rxie_d, txie_q, txie_d, irq_q, irq_d;

   always_comb begin
      rxie_d = rxie_q;
      txie_d = txie_q;
      if (wr && ofs == REG_STATUS) begin
         rxie_d = dbus_dat_w[ST_RXIE];
         txie_d = dbus_dat_w[ST_TXIE];
      end
      irq_d = (rxie_q & rx_valid_q) | (txie_q & tx_idle);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rxie_q <= 1'b0;
         txie_q <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         rxie_q <= rxie_d;
         txie_q <= txie_d;
         irq_q  <= irq_d;
      end
   end

   assign rxie = rxie_q;
   assign txie = txie_q;
   assign irq  = irq_q;
`else
   assign rxie = 1'b0;
   assign txie = 1'b0;
   assign irq  = 1'b0;
`endif

   assign dbus_dat_r = dat_r_q;
   assign uart_txd   = txd_q;

endmodule

// File: tb/tb_j1_uart.sv
// tb/tb_j1_uart.sv - directed self-checking bench for j1_uart
module tb_j1_uart;

   localparam logic [15:0] A_DATA   = 16'h3FFC;
   localparam logic [15:0] A_STATUS = 16'h3FFD;
   localparam logic [15:0] A_DIV    = 16'h3FFE;
   localparam logic [15:0] A_RSVD   = 16'h3FFF;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] adr;
   logic        re, we;
   logic [15:0] dat_w;
   logic [15:0] dbus_dat_r;
   logic        rxd;
   logic        uart_txd;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] mon_q [$];

   j1_uart dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .dbus_adr   (adr),
      .dbus_re    (re),
      .dbus_we    (we),
      .dbus_dat_w (dat_w),
      .dbus_dat_r (dbus_dat_r),
      .uart_rxd   (rxd),
      .uart_txd   (uart_txd),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      adr = a; dat_w = d; we = 1'b1;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
      @(negedge clk);
      adr = a; re = 1'b1;
      @(negedge clk);
      re = 1'b0;
      check(tag, dbus_dat_r, exp);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      rxd = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (8) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (8) @(negedge clk);
      rxd = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   // Serial decoder for the TX line, assuming 4 clocks per bit.
   initial begin : tx_mon
      logic       prev;
      logic [7:0] b;
      prev = 1'b1;
      b    = 8'h00;
      forever begin
         @(negedge clk);
         if (prev === 1'b1 && uart_txd === 1'b0) begin
            repeat (2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (4) @(negedge clk);
               b[i] = uart_txd;
            end
            repeat (4) @(negedge clk);
            mon_q.push_back(b);
            prev = 1'b1;
         end else begin
            prev = uart_txd;
         end
      end
   end

   initial begin : stim
      logic [7:0]  exp_bytes [5];
      logic [15:0] hold;
      logic        exp_bit;
      exp_bytes[0] = 8'hA1; exp_bytes[1] = 8'hB2; exp_bytes[2] = 8'hC3;
      exp_bytes[3] = 8'hD4; exp_bytes[4] = 8'hE5;

      reset_n = 1'b0; adr = 16'h0; re = 1'b0; we = 1'b0; dat_w = 16'h0; rxd = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_dat_r", dbus_dat_r, 16'h0000);
      check("reset_txd", {15'h0, uart_txd}, 16'h0001);
      check("reset_irq", {15'h0, irq}, 16'h0000);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      rd_check("reset_status", A_STATUS, 16'h0002);
      rd_check("reset_div", A_DIV, 16'h01B1);
      rd_check("rsvd_read", A_RSVD, 16'h0000);
      wr(A_DIV, 16'h0003);
      rd_check("div_rw", A_DIV, 16'h0003);

      // 0x55 frame at 4 clocks per bit
      mon_q.delete();
      wr(A_DATA, 16'h0055);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k < 4) exp_bit = 1'b0;
         else if (k < 36) exp_bit = ((k - 4) / 4) % 2 == 0;
         else exp_bit = 1'b1;
         check($sformatf("txd_55_k%0d", k), {15'h0, uart_txd}, {15'h0, exp_bit});
      end
      repeat (2) @(negedge clk);
      rd_check("tx_idle_after_55", A_STATUS, 16'h0002);
      check("mon_55_count", 16'(mon_q.size()), 16'd1);
      if (mon_q.size() > 0) check("mon_55_byte", {8'h00, mon_q[0]}, 16'h0055);

      // five writes fit (one in flight plus four queued), the sixth is dropped
      mon_q.delete();
      for (int i = 0; i < 5; i++) wr(A_DATA, {8'h00, exp_bytes[i]});
      rd_check("fifo_full_status", A_STATUS, 16'h0001);
      wr(A_DATA, 16'h00F6);
      rd_check("txovr_set", A_STATUS, 16'h0021);
      rd_check("txovr_cleared", A_STATUS, 16'h0001);
      repeat (230) @(negedge clk);
      check("tx_frame_count", 16'(mon_q.size()), 16'd5);
      if (mon_q.size() == 5)
         for (int i = 0; i < 5; i++)
            check($sformatf("tx_byte_%0d", i), {8'h00, mon_q[i]}, {8'h00, exp_bytes[i]});
      rd_check("tx_idle_after_burst", A_STATUS, 16'h0002);

      // receive path at 8 clocks per bit
      wr(A_DIV, 16'h0007);
      send_rx(8'hA3, 1'b1);
      rd_check("rx_valid", A_STATUS, 16'h0006);
      check("irq_without_enable", {15'h0, irq}, 16'h0000);
      rd_check("rx_data_a3", A_DATA, 16'h00A3);
      rd_check("rx_valid_cleared", A_STATUS, 16'h0002);

      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      rd_check("rx_overrun", A_STATUS, 16'h000E);
      rd_check("rx_second_byte", A_DATA, 16'h0022);
      rd_check("rx_ovr_cleared", A_STATUS, 16'h0002);

      send_rx(8'h5A, 1'b0);
      rd_check("rx_ferr", A_STATUS, 16'h0012);
      rd_check("rx_ferr_cleared", A_STATUS, 16'h0002);

      @(negedge clk); rxd = 1'b0;
      @(negedge clk); rxd = 1'b1;
      repeat (30) @(negedge clk);
      rd_check("rx_glitch_ignored", A_STATUS, 16'h0002);

      // bus decode corner cases
      rd_check("div_before_unsel", A_DIV, 16'h0007);
      rd_check("unselected_read", 16'h1234, 16'h0000);
      wr(A_RSVD, 16'hFFFF);
      rd_check("rsvd_write_ignored", A_DIV, 16'h0007);
      rd_check("status_before_rw", A_STATUS, 16'h0002);
      @(negedge clk);
      adr = A_DIV; dat_w = 16'h0009; re = 1'b1; we = 1'b1;
      @(negedge clk);
      re = 1'b0; we = 1'b0;
      hold = dbus_dat_r;
      check("re_we_dat_r_held", hold, 16'h0002);
      rd_check("re_we_write_wins", A_DIV, 16'h0009);

      // reset in the middle of a frame
      wr(A_DATA, 16'h0000);
      wr(A_DATA, 16'h0012);
      wr(A_DATA, 16'h0034);
      repeat (2) @(negedge clk);
      check("txd_low_before_reset", {15'h0, uart_txd}, 16'h0000);
      reset_n = 1'b0;
      @(negedge clk);
      check("txd_after_reset", {15'h0, uart_txd}, 16'h0001);
      @(negedge clk);
      reset_n = 1'b1;
      rd_check("status_after_reset", A_STATUS, 16'h0002);
      rd_check("div_after_reset", A_DIV, 16'h01B1);
      repeat (6) @(negedge clk);
      check("txd_idle_after_reset", {15'h0, uart_txd}, 16'h0001);

      wr(A_DIV, 16'h0007);
`ifdef J1_UART_IRQ_EN
      wr(A_STATUS, 16'h0100);
      rd_check("rxie_readback", A_STATUS, 16'h0102);
      send_rx(8'h3C, 1'b1);
      check("irq_rx", {15'h0, irq}, 16'h0001);
      rd_check("rx_data_3c", A_DATA, 16'h003C);
      repeat (2) @(negedge clk);
      check("irq_cleared", {15'h0, irq}, 16'h0000);
`else
      wr(A_STATUS, 16'h0300);
      rd_check("status_write_ignored", A_STATUS, 16'h0002);
      send_rx(8'h3C, 1'b1);
      check("irq_tied_low", {15'h0, irq}, 16'h0000);
      rd_check("rx_data_3c", A_DATA, 16'h003C);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
